// File: rtl/riscv_regfile_param.sv
// Parametrised register file: NUM_RD combinational read ports, one write port, sequential clear engine.
// Optional pending-writer scoreboard enabled by defining RISCV_REGFILE_SCOREBOARD_EN.
module riscv_regfile_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     WE,
  input  logic [ADDR_W-1:0]        WAdr,
  input  logic [DATA_W-1:0]        Din,
  input  logic [NUM_RD*ADDR_W-1:0] RAdr,
  output logic [NUM_RD*DATA_W-1:0] RData,
  input  logic                     ClrReq,
  output logic                     Busy,
  input  logic                     SetPend,
  input  logic [ADDR_W-1:0]        SetAdr,
  output logic [NUM_RD-1:0]        Pend
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t            state;
  logic [ADDR_W:0]   cnt;
  logic              busy;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_ok;

  assign Busy  = busy;
  assign wr_ok = WE && !busy && (WAdr != '0);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= CLEAR;
      cnt   <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          if (cnt == LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        IDLE: begin
          if (ClrReq) begin
            state <= CLEAR;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        default: begin
          state <= CLEAR;
          busy  <= 1'b1;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Storage has no reset; the clear sweep is the only thing that zeroes it.
  always_ff @(posedge Clk) begin
    if (busy)
      mem[cnt[ADDR_W-1:0]] <= '0;
    else if (wr_ok)
      mem[WAdr] <= Din;
  end

  always_comb begin
    RData = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      logic [ADDR_W-1:0] ra;
      ra = RAdr[i*ADDR_W +: ADDR_W];
      if (ra == '0 || busy)
        RData[i*DATA_W +: DATA_W] = '0;
      else if (WE && WAdr == ra)
        RData[i*DATA_W +: DATA_W] = Din;
      else
        RData[i*DATA_W +: DATA_W] = mem[ra];
    end
  end

`ifdef RISCV_REGFILE_SCOREBOARD_EN
  logic [DEPTH-1:0] pend;

  // Set is applied after the write-clear so a same-cycle newer producer wins.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pend <= '0;
    end else if (state == IDLE && ClrReq) begin
      pend <= '0;
    end else begin
      if (wr_ok)
        pend[WAdr] <= 1'b0;
      if (SetPend && SetAdr != '0 && !busy)
        pend[SetAdr] <= 1'b1;
    end
  end

  always_comb begin
    Pend = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      logic [ADDR_W-1:0] ra;
      ra = RAdr[i*ADDR_W +: ADDR_W];
      Pend[i] = pend[ra] && !(wr_ok && WAdr == ra) && (ra != '0);
    end
  end
`else
  logic unused_sb;
  assign unused_sb = ^{SetPend, SetAdr};
  assign Pend      = '0;
`endif

endmodule

// File: tb/tb_riscv_regfile_param.sv
// Directed self-checking bench for riscv_regfile_param (default parameters).
module tb_riscv_regfile_param;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        WE;
  logic [4:0]  WAdr;
  logic [31:0] Din;
  logic [9:0]  RAdr;
  logic [63:0] RData;
  logic        ClrReq;
  logic        Busy;
  logic        SetPend;
  logic [4:0]  SetAdr;
  logic [1:0]  Pend;

  int tests = 0;
  int fails = 0;

  riscv_regfile_param #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .WE(WE), .WAdr(WAdr), .Din(Din),
    .RAdr(RAdr), .RData(RData), .ClrReq(ClrReq), .Busy(Busy),
    .SetPend(SetPend), .SetAdr(SetAdr), .Pend(Pend)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a0);
    RAdr = {a1, a0};
    #1;
  endtask

  task automatic busy_window(input string tag);
    for (int i = 0; i < 32; i++) begin
      chk(tag, {63'd0, Busy}, 64'd1);
      @(negedge Clk);
    end
    chk({tag, "_end"}, {63'd0, Busy}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    Rst_n = 1'b0; WE = 1'b0; WAdr = '0; Din = '0; RAdr = '0;
    ClrReq = 1'b0; SetPend = 1'b0; SetAdr = '0;
    repeat (2) @(negedge Clk);
    #1;
    chk("rst_busy", {63'd0, Busy}, 64'd1);
    chk("rst_pend", {62'd0, Pend}, 64'd0);

    // Release: Busy high for exactly 32 cycles.
    @(negedge Clk);
    Rst_n = 1'b1;
    busy_window("post_rst_busy");

    for (int a = 0; a < 32; a++) begin
      rd(5'(31 - a), 5'(a));
      chk("clr_read", RData, 64'd0);
    end

    // Bypass then stored value.
    WE = 1'b1; WAdr = 5'd5; Din = 32'hDEADBEEF;
    rd(5'd5, 5'd5);
    chk("bypass", RData, {32'hDEADBEEF, 32'hDEADBEEF});
    @(negedge Clk);
    WE = 1'b0;
    rd(5'd0, 5'd5);
    chk("stored5", RData, {32'h0, 32'hDEADBEEF});

    // Writes to entry 0 are dropped and never bypassed.
    WE = 1'b1; WAdr = 5'd0; Din = 32'hFFFFFFFF;
    rd(5'd0, 5'd0);
    chk("zero_bypass", RData, 64'd0);
    @(negedge Clk);
    WE = 1'b0;
    rd(5'd0, 5'd0);
    chk("zero_after", RData, 64'd0);

    // Mixed ports: one bypassed, one from storage.
    WE = 1'b1; WAdr = 5'd10; Din = 32'h0000CAFE;
    @(negedge Clk);
    WAdr = 5'd11; Din = 32'h0000BEEF;
    rd(5'd11, 5'd10);
    chk("mixed_ports", RData, {32'h0000BEEF, 32'h0000CAFE});
    @(negedge Clk);
    WE = 1'b0;
    rd(5'd10, 5'd11);
    chk("swapped_ports", RData, {32'h0000CAFE, 32'h0000BEEF});

    // ClrReq sweep; writes during Busy are dropped.
    WE = 1'b1; WAdr = 5'd7; Din = 32'h00001234;
    @(negedge Clk);
    WE = 1'b0;
    rd(5'd0, 5'd7);
    chk("stored7", RData, {32'h0, 32'h00001234});
    ClrReq = 1'b1;
    @(negedge Clk);
    ClrReq = 1'b0;
    WE = 1'b1; WAdr = 5'd7; Din = 32'h00005678;
    rd(5'd5, 5'd7);
    chk("busy_read", RData, 64'd0);
    for (int i = 0; i < 32; i++) begin
      chk("clrreq_busy", {63'd0, Busy}, 64'd1);
      @(negedge Clk);
    end
    WE = 1'b0;
    chk("clrreq_busy_end", {63'd0, Busy}, 64'd0);
    rd(5'd5, 5'd7);
    chk("post_clear", RData, 64'd0);

    // Reset mid-sweep at cnt=10 restarts the full sweep.
    ClrReq = 1'b1;
    @(negedge Clk);
    ClrReq = 1'b0;
    repeat (10) @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    chk("midrst_busy", {63'd0, Busy}, 64'd1);
    @(negedge Clk);
    Rst_n = 1'b1;
    busy_window("midrst_sweep");

    // Scoreboard behaviour.
    RAdr = {5'd0, 5'd3};
    SetPend = 1'b1; SetAdr = 5'd3;
    #1;
    chk("pend_before_set", {62'd0, Pend}, 64'd0);
    @(negedge Clk);
    SetPend = 1'b0;
    #1;
`ifdef RISCV_REGFILE_SCOREBOARD_EN
    chk("pend_set", {62'd0, Pend}, 64'd1);
`else
    chk("pend_set_off", {62'd0, Pend}, 64'd0);
`endif
    WE = 1'b1; WAdr = 5'd3; Din = 32'h00000033;
    #1;
    chk("pend_write_cycle", {62'd0, Pend}, 64'd0);
    @(negedge Clk);
    WE = 1'b0;
    #1;
    chk("pend_after_write", {62'd0, Pend}, 64'd0);
    SetPend = 1'b1; SetAdr = 5'd3; WE = 1'b1; WAdr = 5'd3; Din = 32'h00000044;
    @(negedge Clk);
    SetPend = 1'b0; WE = 1'b0;
    rd(5'd3, 5'd3);
`ifdef RISCV_REGFILE_SCOREBOARD_EN
    chk("pend_set_wins", {62'd0, Pend}, 64'd3);
`else
    chk("pend_set_wins_off", {62'd0, Pend}, 64'd0);
`endif
    chk("data_set_write", RData, {32'h00000044, 32'h00000044});
    SetPend = 1'b1; SetAdr = 5'd0;
    @(negedge Clk);
    SetPend = 1'b0;
    rd(5'd0, 5'd0);
    chk("pend_addr0", {62'd0, Pend}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
